alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Control sequencer that drives the multi-stage ALU datapath from the register-file side of the shared 10-bit bus. Accepts one 10-bit instruction per START handshake and issues, cycle by cycle, the bus-driver selects, register loads, A/G register enables and the 4-bit ALU function code. It is the initiator for the ALU stage's enable/control interface and sits between instruction fetch and the datapath.

## Interface
Parameters:
- NREG, 8, number of general registers; one-hot select width. Fixed at 8 by the 3-bit register fields.

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  instruction valid; sampled only in IDLE
- INSTR  in  10  [9:6] opcode/FN, [5:3] Rx (destination and first operand), [2:0] Ry (second operand)
- ALUcont  out  4  ALU function code to the ALU stage
- enA  out  1  load enable for the ALU A register
- enGin  out  1  load enable for the ALU G register
- enGout  out  1  G register tri-state drive onto bus
- RinSel  out  8  one-hot register load enables
- RoutSel  out  8  one-hot register bus-drive enables
- extOut  out  1  drive external data (DIN) onto bus
- BUSY  out  1  high in every non-IDLE state
- DONE  out  1  high for exactly the final cycle of an instruction

## Operation
- Reset: state IDLE, instruction register 0; all outputs 0.
- IDLE: START=1 latches INSTR into internal IR and moves to T1; START=0 stays in IDLE.
- Opcode 4'b0000 LOAD: T1 extOut=1, RinSel[Rx]=1, DONE=1; -> IDLE.
- Opcode 4'b0001 MOV: T1 RoutSel[Ry]=1, RinSel[Rx]=1, DONE=1; -> IDLE. Rx==Ry is legal (register reloads itself).
- Any other opcode = ALU op:
  - T1: RoutSel[Rx]=1, enA=1; -> T2.
  - T2: RoutSel[Ry]=1, ALUcont=IR[9:6], enGin=1; -> T3.
  - T3: enGout=1, RinSel[Rx]=1, DONE=1; -> IDLE.
- ALUcont is 4'b0000 outside T2.
- Bus exclusivity: in every cycle at most one of extOut, enGout, any RoutSel bit is high. Required invariant.
- Outputs are Moore: decoded from state and IR only, never from the live INSTR/START inputs.
- START while BUSY: ignored; IR is not modified mid-instruction.
- RST asserted mid-instruction: immediate return to IDLE, all outputs 0. Partial results already loaded into A/G are abandoned; nothing is written to Rx.

## Timing
- Latency START to DONE: LOAD/MOV 1 cycle after the accepting edge; ALU op 3 cycles.
- Throughput: back-to-back START accepted in the IDLE cycle after DONE. Minimum instruction spacing is 2 cycles (LOAD/MOV) or 4 cycles (ALU).
- Datapath registers capture on the rising edge that ends the state asserting their enable.

## Configuration
- ALU_SEQ_ERR_EN defined: adds output ERR (1 bit).
  - ERR is sticky and is set on any cycle where START=1 and BUSY=1.
  - ERR is cleared only by RST.
- ALU_SEQ_ERR_EN undefined: no ERR port. START while BUSY is silently ignored.

## Structure
- Package alu_seq_pkg contains:
  - state enum {IDLE, T1, T2, T3}
  - opcode constants OP_LOAD=4'b0000 and OP_MOV=4'b0001
  - INSTR field slice localparams
- Sub-module dec3to8: 3-bit to one-hot-8 decoder with an enable. Instantiated twice, once for RinSel and once for RoutSel.

## Test plan
- Reset: RST=1 mid-T2 of an ALU op -> next cycle IDLE, all outputs 0, BUSY=0; START afterwards behaves normally.
- LOAD: INSTR=10'b0000_011_000 with START -> one cycle with extOut=1, RinSel=8'b0000_1000, DONE=1; then IDLE.
- MOV: INSTR=10'b0001_010_101 -> one cycle with RoutSel=8'b0010_0000, RinSel=8'b0000_0100, DONE=1.
- ALU op: INSTR=10'b0110_001_010 -> T1 RoutSel=8'b0000_0010 and enA=1; T2 RoutSel=8'b0000_0100, ALUcont=4'b0110, enGin=1; T3 enGout=1, RinSel=8'b0000_0010, DONE=1.
- START held high during an ALU op with a different INSTR -> sequence unchanged. With ALU_SEQ_ERR_EN, ERR=1 from the next cycle and stays 1 until RST.
- Random instruction stream (1000 instructions) -> assertion that at most one bus driver is active per cycle never fires; DONE count equals the number of accepted STARTs.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      T1   = 2'd1,
      T2   = 2'd2,
      T3   = 2'd3
   } state_t;

   localparam logic [3:0] OP_LOAD = 4'b0000;
   localparam logic [3:0] OP_MOV  = 4'b0001;

   localparam int OP_HI = 9;
   localparam int OP_LO = 6;
   localparam int RX_HI = 5;
   localparam int RX_LO = 3;
   localparam int RY_HI = 2;
   localparam int RY_LO = 0;

   // Anything that is neither LOAD nor MOV runs the three-step ALU sequence.
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op != OP_LOAD) && (op != OP_MOV);
   endfunction

endpackage

// File: rtl/alu_op_sequencer_dec3to8.sv
// 3-bit index to one-hot-8 decoder with enable (module dec3to8).
module dec3to8 (
   input  logic       en,
   input  logic [2:0] sel,
   output logic [7:0] onehot
);

   // Decode the index into a single enabled bit.
   always_comb begin
      onehot = 8'b0000_0000;
      if (en) begin
         onehot[sel] = 1'b1;
      end else begin
         onehot = 8'b0000_0000;
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer driving the ALU datapath controls from a 10-bit instruction.
// Optional ERR output (sticky START-while-busy flag) enabled by ALU_SEQ_ERR_EN.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NREG = 8
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            START,
   input  logic [9:0]      INSTR,
   output logic [3:0]      ALUcont,
   output logic            enA,
   output logic            enGin,
   output logic            enGout,
   output logic [NREG-1:0] RinSel,
   output logic [NREG-1:0] RoutSel,
   output logic            extOut,
   output logic            BUSY,
   output logic            DONE
`ifdef ALU_SEQ_ERR_EN
   ,
   output logic            ERR
`endif
);

   state_t     state;
   state_t     next_state;
   logic [9:0] ir;
   logic [9:0] next_ir;

   logic [3:0] next_op;
   logic [2:0] next_rx;
   logic [2:0] next_ry;

   logic       rin_en;
   logic [2:0] rin_idx;
   logic       rout_en;
   logic [2:0] rout_idx;
   logic [3:0] alu_d;
   logic       en_a_d;
   logic       en_g_in_d;
   logic       en_g_out_d;
   logic       ext_d;
   logic       busy_d;
   logic       done_d;
   logic [7:0] rin_dec;
   logic [7:0] rout_dec;

   assign next_op = next_ir[OP_HI:OP_LO];
   assign next_rx = next_ir[RX_HI:RX_LO];
   assign next_ry = next_ir[RY_HI:RY_LO];

   // Next-state and instruction capture; IR only changes on an accepted START.
   always_comb begin
      next_state = state;
      next_ir    = ir;
      case (state)
         IDLE: begin
            if (START) begin
               next_ir    = INSTR;
               next_state = T1;
            end else begin
               next_state = IDLE;
            end
         end
         T1: begin
            if (is_alu_op(ir[OP_HI:OP_LO])) begin
               next_state = T2;
            end else begin
               next_state = IDLE;
            end
         end
         T2:      next_state = T3;
         T3:      next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Decode the controls of the upcoming state so they can be registered.
   always_comb begin
      rin_en     = 1'b0;
      rin_idx    = 3'd0;
      rout_en    = 1'b0;
      rout_idx   = 3'd0;
      alu_d      = 4'b0000;
      en_a_d     = 1'b0;
      en_g_in_d  = 1'b0;
      en_g_out_d = 1'b0;
      ext_d      = 1'b0;
      done_d     = 1'b0;
      busy_d     = (next_state != IDLE);
      case (next_state)
         T1: begin
            if (next_op == OP_LOAD) begin
               ext_d   = 1'b1;
               rin_en  = 1'b1;
               rin_idx = next_rx;
               done_d  = 1'b1;
            end else if (next_op == OP_MOV) begin
               rout_en  = 1'b1;
               rout_idx = next_ry;
               rin_en   = 1'b1;
               rin_idx  = next_rx;
               done_d   = 1'b1;
            end else begin
               rout_en  = 1'b1;
               rout_idx = next_rx;
               en_a_d   = 1'b1;
            end
         end
         T2: begin
            rout_en   = 1'b1;
            rout_idx  = next_ry;
            alu_d     = next_op;
            en_g_in_d = 1'b1;
         end
         T3: begin
            en_g_out_d = 1'b1;
            rin_en     = 1'b1;
            rin_idx    = next_rx;
            done_d     = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   dec3to8 u_rin_dec (
      .en     (rin_en),
      .sel    (rin_idx),
      .onehot (rin_dec)
   );

   dec3to8 u_rout_dec (
      .en     (rout_en),
      .sel    (rout_idx),
      .onehot (rout_dec)
   );

   // State, IR and registered control outputs; reset abandons any partial op.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         ir      <= 10'd0;
         ALUcont <= 4'b0000;
         enA     <= 1'b0;
         enGin   <= 1'b0;
         enGout  <= 1'b0;
         RinSel  <= '0;
         RoutSel <= '0;
         extOut  <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         state   <= next_state;
         ir      <= next_ir;
         ALUcont <= alu_d;
         enA     <= en_a_d;
         enGin   <= en_g_in_d;
         enGout  <= en_g_out_d;
         RinSel  <= rin_dec;
         RoutSel <= rout_dec;
         extOut  <= ext_d;
         BUSY    <= busy_d;
         DONE    <= done_d;
      end
   end

`ifdef ALU_SEQ_ERR_EN
   // Sticky flag for a START that arrived while an instruction was in flight.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ERR <= 1'b0;
      end else begin
         ERR <= ERR | (START & BUSY);
      end
   end
`endif

endmodule
